// File: rtl/hazard_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates data-memory wait,
// load-use hazards and control-flow redirects, sequences multi-cycle bubbles
// and keeps saturating stall/redirect statistics.
module hazard_sequencer #(
   parameter int unsigned LOAD_USE_BUBBLES = 1,
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             jump,
   input  logic             bne,
   input  logic             jr,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             mem_busy,
   input  logic             clear_stats,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_flush,
   output logic             id_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       state
);

   localparam int unsigned BUB_W = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_BAD      = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [BUB_W-1:0] cnt_q;
   logic [BUB_W-1:0] cnt_d;
   logic             stall_inc;
   logic             flush_inc;
   logic             lu_hazard;
   logic             redirect;

   // Hazard and redirect detection from the ID/EX operand fields
   assign lu_hazard = id_ex_memread && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
   assign redirect  = jump | bne | jr;

   assign state = state_q;

   // Next-state, bubble counter and pipeline control outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
      pipe_hold   = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_flush    = 1'b1;
         id_flush    = 1'b1;
         state_d     = ST_RUN;
         cnt_d       = '0;
      end else if (mem_busy) begin
         // Whole pipeline frozen; sequencing resumes where it left off
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
         stall_inc   = 1'b1;
      end else begin
         case (state_q)
            ST_LD_STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_flush    = 1'b1;
               stall_inc   = 1'b1;
               cnt_d       = cnt_q - BUB_W'(1);
               if (cnt_q <= BUB_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            ST_REDIRECT: begin
               // Wrong-path fetches are discarded; further redirects ignored
               if_flush = 1'b1;
               cnt_d    = cnt_q - BUB_W'(1);
               if (cnt_q <= BUB_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               if (lu_hazard) begin
                  // Branch operands are not valid yet, so any redirect waits
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_flush    = 1'b1;
                  stall_inc   = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_d = ST_LD_STALL;
                     cnt_d   = BUB_W'(LOAD_USE_BUBBLES - 1);
                  end
               end else if (redirect) begin
                  // A plain jump resolves early enough that ID stays valid
                  if_flush  = 1'b1;
                  id_flush  = bne | jr;
                  flush_inc = 1'b1;
                  if (REDIRECT_BUBBLES > 1) begin
                     state_d = ST_REDIRECT;
                     cnt_d   = BUB_W'(REDIRECT_BUBBLES - 1);
                  end
               end
               // Illegal encoding drops straight back to RUN
               if (state_q == ST_BAD) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   // State, bubble counter and saturating statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (clear_stats) begin
            stall_count <= '0;
            flush_count <= '0;
         end else begin
            if (stall_inc && (stall_count != {CNT_W{1'b1}}))
               stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != {CNT_W{1'b1}}))
               flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: one default instance and one with
// LOAD_USE_BUBBLES=3, REDIRECT_BUBBLES=4, CNT_W=4.
module tb_hazard_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Instance A inputs/outputs (default parameters)
   logic       a_reset, a_jump, a_bne, a_jr, a_memread, a_mem_busy, a_clear;
   logic [4:0] a_ex_rt, a_rs, a_rt;
   logic       a_pcw, a_ifidw, a_iff, a_idf, a_hold;
   logic [15:0] a_stall, a_flush;
   logic [1:0] a_state;

   // Instance B inputs/outputs
   logic       b_reset, b_jump, b_bne, b_jr, b_memread, b_mem_busy, b_clear;
   logic [4:0] b_ex_rt, b_rs, b_rt;
   logic       b_pcw, b_ifidw, b_iff, b_idf, b_hold;
   logic [3:0] b_stall, b_flush;
   logic [1:0] b_state;

   hazard_sequencer u_a (
      .clk(clk), .reset(a_reset), .jump(a_jump), .bne(a_bne), .jr(a_jr),
      .id_ex_memread(a_memread), .id_ex_rt(a_ex_rt), .if_id_rs(a_rs), .if_id_rt(a_rt),
      .mem_busy(a_mem_busy), .clear_stats(a_clear),
      .pc_write(a_pcw), .if_id_write(a_ifidw), .if_flush(a_iff), .id_flush(a_idf),
      .pipe_hold(a_hold), .stall_count(a_stall), .flush_count(a_flush), .state(a_state)
   );

   hazard_sequencer #(.LOAD_USE_BUBBLES(3), .REDIRECT_BUBBLES(4), .CNT_W(4)) u_b (
      .clk(clk), .reset(b_reset), .jump(b_jump), .bne(b_bne), .jr(b_jr),
      .id_ex_memread(b_memread), .id_ex_rt(b_ex_rt), .if_id_rs(b_rs), .if_id_rt(b_rt),
      .mem_busy(b_mem_busy), .clear_stats(b_clear),
      .pc_write(b_pcw), .if_id_write(b_ifidw), .if_flush(b_iff), .id_flush(b_idf),
      .pipe_hold(b_hold), .stall_count(b_stall), .flush_count(b_flush), .state(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed control outputs {pc_write, if_id_write, if_flush, id_flush, pipe_hold}
   function automatic logic [31:0] a_ctl();
      return 32'({a_pcw, a_ifidw, a_iff, a_idf, a_hold});
   endfunction
   function automatic logic [31:0] b_ctl();
      return 32'({b_pcw, b_ifidw, b_iff, b_idf, b_hold});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_reset = 1'b1; a_jump = 0; a_bne = 0; a_jr = 0; a_memread = 0; a_mem_busy = 0;
      a_clear = 0; a_ex_rt = 0; a_rs = 0; a_rt = 0;
      b_reset = 1'b1; b_jump = 0; b_bne = 0; b_jr = 0; b_memread = 0; b_mem_busy = 0;
      b_clear = 0; b_ex_rt = 0; b_rs = 0; b_rt = 0;

      // Reset held two cycles
      #1;
      chk("a_reset_ctl_c1", a_ctl(), 32'b00110);
      cyc();
      chk("a_reset_ctl_c2", a_ctl(), 32'b00110);
      chk("b_reset_ctl", b_ctl(), 32'b00110);
      cyc();
      chk("a_reset_state", 32'(a_state), 32'd0);
      a_reset = 0; b_reset = 0;
      #1;
      chk("a_release_ctl", a_ctl(), 32'b11000);
      chk("a_release_stall", 32'(a_stall), 32'd0);
      chk("a_release_flush", 32'(a_flush), 32'd0);
      chk("b_release_state", 32'(b_state), 32'd0);
      cyc();

      // Load-use on rs
      a_memread = 1; a_ex_rt = 5'd5; a_rs = 5'd5; #1;
      chk("a_lu_rs_ctl", a_ctl(), 32'b00010);
      cyc();
      chk("a_lu_rs_stall", 32'(a_stall), 32'd1);
      chk("a_lu_rs_state", 32'(a_state), 32'd0);
      // Destination r0 never stalls
      a_ex_rt = 5'd0; a_rs = 5'd0; #1;
      chk("a_lu_r0_ctl", a_ctl(), 32'b11000);
      cyc();
      chk("a_lu_r0_stall", 32'(a_stall), 32'd1);
      // Load-use on rt
      a_ex_rt = 5'd7; a_rt = 5'd7; a_rs = 5'd3; #1;
      chk("a_lu_rt_ctl", a_ctl(), 32'b00010);
      cyc();
      chk("a_lu_rt_stall", 32'(a_stall), 32'd2);
      // Matching register but not a load
      a_memread = 0; #1;
      chk("a_noload_ctl", a_ctl(), 32'b11000);
      cyc();
      a_rt = 0; a_rs = 0; a_ex_rt = 0;

      // Redirects: bne bubbles ID, jump alone does not
      a_bne = 1; #1;
      chk("a_bne_ctl", a_ctl(), 32'b11110);
      cyc();
      chk("a_bne_flush", 32'(a_flush), 32'd1);
      a_bne = 0; a_jump = 1; #1;
      chk("a_jump_ctl", a_ctl(), 32'b11100);
      cyc();
      chk("a_jump_flush", 32'(a_flush), 32'd2);
      a_jump = 0;

      // Load-use suppresses a simultaneous jr
      a_memread = 1; a_ex_rt = 5'd5; a_rs = 5'd5; a_jr = 1; #1;
      chk("a_lu_jr_ctl", a_ctl(), 32'b00010);
      cyc();
      chk("a_lu_jr_flush", 32'(a_flush), 32'd2);
      chk("a_lu_jr_stall", 32'(a_stall), 32'd3);
      a_memread = 0; #1;
      chk("a_jr_ctl", a_ctl(), 32'b11110);
      cyc();
      chk("a_jr_flush", 32'(a_flush), 32'd3);

      // mem_busy dominates a redirect
      a_jr = 0; a_bne = 1; a_mem_busy = 1; #1;
      chk("a_busy_ctl", a_ctl(), 32'b00001);
      cyc();
      chk("a_busy_stall", 32'(a_stall), 32'd4);
      chk("a_busy_flush", 32'(a_flush), 32'd3);
      // clear_stats wins over the busy increment
      a_clear = 1;
      cyc();
      chk("a_clear_stall", 32'(a_stall), 32'd0);
      chk("a_clear_flush", 32'(a_flush), 32'd0);
      a_clear = 0; a_bne = 0; a_mem_busy = 0;

      // Instance B: 3-cycle load-use with 2 busy cycles in the 2nd bubble
      b_memread = 1; b_ex_rt = 5'd5; b_rs = 5'd5; #1;
      chk("b_lu_c1_ctl", b_ctl(), 32'b00010);
      cyc();
      chk("b_lu_c1_state", 32'(b_state), 32'd1);
      chk("b_lu_c1_stall", 32'(b_stall), 32'd1);
      b_memread = 0; b_mem_busy = 1; #1;
      chk("b_lu_busy_ctl", b_ctl(), 32'b00001);
      cyc();
      chk("b_lu_busy1_state", 32'(b_state), 32'd1);
      cyc();
      chk("b_lu_busy2_state", 32'(b_state), 32'd1);
      chk("b_lu_busy2_stall", 32'(b_stall), 32'd3);
      b_mem_busy = 0; #1;
      chk("b_lu_c2_ctl", b_ctl(), 32'b00010);
      cyc();
      chk("b_lu_c2_state", 32'(b_state), 32'd1);
      #1;
      chk("b_lu_c3_ctl", b_ctl(), 32'b00010);
      cyc();
      chk("b_lu_done_state", 32'(b_state), 32'd0);
      chk("b_lu_done_stall", 32'(b_stall), 32'd5);
      #1;
      chk("b_lu_after_ctl", b_ctl(), 32'b11000);
      b_rs = 0; b_ex_rt = 0;

      // Saturation of the 4-bit stall counter
      b_mem_busy = 1;
      for (int i = 0; i < 20; i++) cyc();
      chk("b_sat_stall", 32'(b_stall), 32'd15);
      b_clear = 1;
      cyc();
      chk("b_clear_stall", 32'(b_stall), 32'd0);
      b_clear = 0; b_mem_busy = 0;

      // Four-cycle redirect, with a redirect ignored during the bubble
      b_jump = 1; #1;
      chk("b_rd_ctl", b_ctl(), 32'b11100);
      cyc();
      chk("b_rd_state", 32'(b_state), 32'd2);
      chk("b_rd_flush", 32'(b_flush), 32'd1);
      b_jump = 0; b_bne = 1; #1;
      chk("b_rd_bub_ctl", b_ctl(), 32'b11100);
      cyc();
      chk("b_rd_bub_flush", 32'(b_flush), 32'd1);
      chk("b_rd_bub_state", 32'(b_state), 32'd2);
      b_bne = 0;
      cyc();
      chk("b_rd_bub2_state", 32'(b_state), 32'd2);
      cyc();
      chk("b_rd_end_state", 32'(b_state), 32'd0);

      // Reset in the middle of a redirect bubble
      b_jump = 1;
      cyc();
      b_jump = 0;
      cyc();
      chk("b_rd2_state", 32'(b_state), 32'd2);
      b_reset = 1; #1;
      chk("b_mid_reset_ctl", b_ctl(), 32'b00110);
      cyc();
      chk("b_mid_reset_state", 32'(b_state), 32'd0);
      chk("b_mid_reset_flush", 32'(b_flush), 32'd0);
      b_reset = 0; #1;
      chk("b_post_reset_ctl", b_ctl(), 32'b11000);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
